// File: rtl/fft_sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage feeding the twiddle multiplier.
// Emits one registered butterfly result per advance, paired with its Q8 twiddle.
module fft_sdf_bf_stage #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_r,
  input  logic [DW-1:0]        in_i,
  input  logic                 flush,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] W_real,
  output logic signed [DW-1:0] W_imag,
  output logic                 out_first
);

  localparam int LOGN = $clog2(N);
  localparam int H    = N / 2;

  // Q8 twiddles for a 16-point circle; smaller N index it with a stride.
  function automatic int cos16(input int unsigned j);
    case (j)
      0: cos16 = 256;
      1: cos16 = 237;
      2: cos16 = 181;
      3: cos16 = 98;
      4: cos16 = 0;
      5: cos16 = -98;
      6: cos16 = -181;
      7: cos16 = -237;
      default: cos16 = 0;
    endcase
  endfunction

  function automatic int nsin16(input int unsigned j);
    case (j)
      0: nsin16 = 0;
      1: nsin16 = -98;
      2: nsin16 = -181;
      3: nsin16 = -237;
      4: nsin16 = -256;
      5: nsin16 = -237;
      6: nsin16 = -181;
      7: nsin16 = -98;
      default: nsin16 = 0;
    endcase
  endfunction

  logic [LOGN-1:0]    cnt;
  logic               pending;
  logic signed [DW:0] dl_r [H];
  logic signed [DW:0] dl_i [H];

  logic               adv;
  logic               phase_b;
  logic signed [DW:0] smp_r, smp_i;
  logic signed [DW:0] pop_r, pop_i;
  logic signed [DW:0] sum_r, sum_i;
  logic signed [DW:0] dif_r, dif_i;
  logic signed [DW:0] push_r, push_i;
  logic signed [DW:0] sel_r, sel_i;
  logic signed [DW-1:0] tw_r, tw_i;
  int unsigned        rom_idx;

  always_comb begin
    adv     = in_valid | flush;
    phase_b = cnt[LOGN-1];
    smp_r   = in_valid ? {in_r[DW-1], in_r} : '0;
    smp_i   = in_valid ? {in_i[DW-1], in_i} : '0;
    pop_r   = dl_r[H-1];
    pop_i   = dl_i[H-1];
    sum_r   = pop_r + smp_r;
    sum_i   = pop_i + smp_i;
    dif_r   = pop_r - smp_r;
    dif_i   = pop_i - smp_i;
    push_r  = phase_b ? dif_r : smp_r;
    push_i  = phase_b ? dif_i : smp_i;
    sel_r   = phase_b ? sum_r : pop_r;
    sel_i   = phase_b ? sum_i : pop_i;
    rom_idx = 32'(cnt) << (4 - LOGN);
    tw_r    = DW'(cos16(rom_idx));
    tw_i    = DW'(nsin16(rom_idx));
    if (phase_b) begin
      tw_r = DW'(256);
      tw_i = '0;
    end
  end

  // Delay line carries no reset; pending masks its contents until refilled.
  always_ff @(posedge clk) begin
    if (adv) begin
      dl_r[0] <= push_r;
      dl_i[0] <= push_i;
      for (int unsigned j = H - 1; j > 0; j--) begin
        dl_r[j] <= dl_r[j-1];
        dl_i[j] <= dl_i[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      W_real    <= '0;
      W_imag    <= '0;
    end else if (adv) begin
      cnt       <= cnt + 1'b1;
      if (cnt == LOGN'(N - 1))
        pending <= 1'b1;
      else if (cnt == LOGN'(H - 1))
        pending <= 1'b0;
      out_valid <= phase_b | pending;
      out_first <= (cnt == LOGN'(H));
      out_r     <= DW'(sel_r >>> 1);
      out_i     <= DW'(sel_i >>> 1);
      W_real    <= tw_r;
      W_imag    <= tw_i;
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_sdf_bf_stage.sv
// Self-checking bench for fft_sdf_bf_stage: frame-level reference model plus
// literal expectations for the directed scenarios.
module tb_fft_sdf_bf_stage;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int H  = N / 2;
  localparam real PI = 3.141592653589793;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 flush;
  logic signed [DW-1:0] in_r, in_i;
  logic                 out_valid, out_first;
  logic signed [DW-1:0] out_r, out_i, W_real, W_imag;

  fft_sdf_bf_stage #(.N(N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .flush(flush), .out_valid(out_valid), .out_r(out_r), .out_i(out_i),
    .W_real(W_real), .W_imag(W_imag), .out_first(out_first)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference model: frame buffer of first halves and pending differences.
  int xr [H], xi [H], pdr [H], pdi [H];
  int pos = 0;
  bit pend = 0;
  bit exp_valid = 0, exp_first = 0;
  int exp_r = 0, exp_i = 0, exp_wr = 0, exp_wi = 0;

  function automatic int tw_re(input int k);
    return int'(256.0 * $cos(2.0 * PI * k / N));
  endfunction
  function automatic int tw_im(input int k);
    return -int'(256.0 * $sin(2.0 * PI * k / N));
  endfunction

  always @(posedge clk) begin
    int sr, si, j;
    if (reset) begin
      pos = 0; pend = 0; exp_valid = 0; exp_first = 0;
      exp_r = 0; exp_i = 0; exp_wr = 0; exp_wi = 0;
    end else if (in_valid || flush) begin
      sr = in_valid ? int'(in_r) : 0;
      si = in_valid ? int'(in_i) : 0;
      if (pos < H) begin
        exp_valid = pend;
        exp_first = 0;
        exp_r = pdr[pos] >>> 1;
        exp_i = pdi[pos] >>> 1;
        exp_wr = tw_re(pos);
        exp_wi = tw_im(pos);
        xr[pos] = sr;
        xi[pos] = si;
        if (pos == H - 1) pend = 0;
      end else begin
        j = pos - H;
        exp_valid = 1;
        exp_first = (pos == H);
        exp_r = (xr[j] + sr) >>> 1;
        exp_i = (xi[j] + si) >>> 1;
        exp_wr = 256;
        exp_wi = 0;
        pdr[j] = xr[j] - sr;
        pdi[j] = xi[j] - si;
        if (pos == N - 1) pend = 1;
      end
      pos = (pos + 1) % N;
    end else begin
      exp_valid = 0;
      exp_first = 0;
    end
  end

  bit chk_en = 0;
  int lr[$], li[$], lwr[$], lwi[$], lf[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("out_first", int'(out_first), int'(exp_first));
      if (exp_valid) begin
        chk("out_r", int'(out_r), exp_r);
        chk("out_i", int'(out_i), exp_i);
        chk("W_real", int'(W_real), exp_wr);
        chk("W_imag", int'(W_imag), exp_wi);
      end
      if (out_valid) begin
        lr.push_back(int'(out_r));
        li.push_back(int'(out_i));
        lwr.push_back(int'(W_real));
        lwi.push_back(int'(W_imag));
        lf.push_back(int'(out_first));
      end
    end
  end

  task automatic step(input logic v, input logic f, input int r, input int i);
    @(negedge clk);
    in_valid = v;
    flush    = f;
    in_r     = DW'(r);
    in_i     = DW'(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_r = '0; in_i = '0;
    @(negedge clk);
    reset = 1'b0;
    lr.delete(); li.delete(); lwr.delete(); lwi.delete(); lf.delete();
  endtask

  task automatic send_frames(input bit gaps);
    int s1 [8] = '{100, 200, 300, 400, 1, 2, 3, 4};
    for (int k = 0; k < 8; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      step(1'b1, 1'b0, s1[k], 0);
    end
    for (int k = 0; k < 2; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      step(1'b0, 1'b1, 0, 0);
    end
    idle(3);
  endtask

  int ref_r[$], ref_wi[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_r = '0; in_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_first", int'(out_first), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_i", int'(out_i), 0);
    chk("rst_W_real", int'(W_real), 0);
    chk("rst_W_imag", int'(W_imag), 0);
    chk_en = 1;

    // Single frame then two flushes
    do_reset();
    step(1, 0, 100, 0); step(1, 0, 200, 0); step(1, 0, 300, 0); step(1, 0, 400, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    idle(3);
    chk("t1_count", lr.size(), 4);
    if (lr.size() >= 4) begin
      chk("t1_s0_r", lr[0], 200);   chk("t1_s0_wr", lwr[0], 256); chk("t1_s0_first", lf[0], 1);
      chk("t1_s1_r", lr[1], 300);   chk("t1_s1_wi", lwi[1], 0);   chk("t1_s1_first", lf[1], 0);
      chk("t1_d0_r", lr[2], -100);  chk("t1_d0_wr", lwr[2], 256); chk("t1_d0_wi", lwi[2], 0);
      chk("t1_d1_r", lr[3], -100);  chk("t1_d1_wr", lwr[3], 0);   chk("t1_d1_wi", lwi[3], -256);
    end

    // Back-to-back frames, gapless
    do_reset();
    send_frames(0);
    ref_r = lr;
    ref_wi = lwi;
    begin
      int er [8] = '{200, 300, -100, -100, 2, 3, -1, -1};
      int ew [8] = '{0, 0, 0, -256, 0, 0, 0, -256};
      chk("t2_count", lr.size(), 8);
      if (lr.size() >= 8)
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("t2_r%0d", k), lr[k], er[k]);
          chk($sformatf("t2_wi%0d", k), lwi[k], ew[k]);
        end
    end

    // Same frames with random input gaps
    do_reset();
    send_frames(1);
    chk("t3_count", lr.size(), ref_r.size());
    if (lr.size() == ref_r.size())
      for (int k = 0; k < lr.size(); k++) begin
        chk($sformatf("t3_r%0d", k), lr[k], ref_r[k]);
        chk($sformatf("t3_wi%0d", k), lwi[k], ref_wi[k]);
      end

    // Full-scale negative frame then flush
    do_reset();
    for (int k = 0; k < N; k++) step(1, 0, -32768, -32768);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    idle(3);
    chk("t4_count", lr.size(), 4);
    if (lr.size() >= 4) begin
      chk("t4_sum_r", lr[0], -32768); chk("t4_sum_i", li[0], -32768);
      chk("t4_diff_r", lr[2], 0);     chk("t4_diff_i", li[3], 0);
    end

    // Floor rounding of -1/2
    do_reset();
    step(1, 0, -1, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    idle(2);
    chk("t5_count", lr.size(), 2);
    if (lr.size() >= 1) chk("t5_floor", lr[0], -1);

    // Reset mid-frame, then a fresh frame
    do_reset();
    step(1, 0, 100, 0); step(1, 0, 200, 0);
    do_reset();
    step(1, 0, 5, 0); step(1, 0, 6, 0); step(1, 0, 7, 0); step(1, 0, 8, 0);
    idle(3);
    chk("t6_count", lr.size(), 2);
    if (lr.size() >= 2) begin
      chk("t6_s0_r", lr[0], 6); chk("t6_s0_first", lf[0], 1);
      chk("t6_s1_r", lr[1], 7);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_sdf_bf_stage.md
# fft_sdf_bf_stage

Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT datapath. It sits directly upstream of the complex twiddle multiplier. Each cycle it hands the multiplier one butterfly result (`out_r`/`out_i`) and the matching Q8 twiddle (`W_real`/`W_imag`), both registered and aligned. Sums carry twiddle W^0; differences carry W^k.

## Interface
Parameters:
- `N`, 4: FFT points per frame; power of two, 4..16.
- `DW`, 16: sample width per component, signed.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input sample valid.
- `in_r`, `in_i`  in  DW each  input sample, natural order, signed.
- `flush`  in  1  when `in_valid`=0, inject one zero sample to drain pending differences.
- `out_valid`  out  1  output sample valid.
- `out_r`, `out_i`  out  DW each  butterfly result, signed.
- `W_real`, `W_imag`  out  DW each  twiddle for the same output sample, signed Q8 (256 = 1.0).
- `out_first`  out  1  high with the first sum of each frame.

## Operation
- Advance condition: `adv` = `in_valid` | `flush`. The sample used is (`in_r`,`in_i`) when `in_valid`=1, otherwise (0,0). When `in_valid` and `flush` are both high, `in_valid` wins.
- Counter `cnt`, log2(N) bits, increments on `adv` and wraps from N-1 to 0.
- Delay line: N/2 complex entries, DW+1 bits each. It shifts by exactly one entry per `adv` and never moves without `adv`.
- Phase A (`cnt` < N/2):
  - Push the incoming sample into the delay line.
  - Pop the oldest entry `d`.
  - Output `d >>> 1` with twiddle W^k, k = `cnt`.
  - `out_valid` = `pending`.
- Phase B (`cnt` >= N/2):
  - Pop `a`; the incoming sample is `b`.
  - Output `(a+b) >>> 1` with twiddle (256, 0).
  - Push `a-b`.
  - `out_valid` = 1.
  - `out_first` = 1 when `cnt` = N/2.
- `pending`:
  - Set on `adv` at `cnt` = N-1.
  - Cleared on `adv` at `cnt` = N/2-1, unless that same event sets it, which it cannot.
- Arithmetic:
  - Sum and difference are computed at DW+1 bits, sign-extended.
  - The output is an arithmetic right shift by 1 (floor, so -1/2 gives -1). The result always fits DW bits; no saturation is needed.
- Twiddle ROM, indices k = 0..N/2-1:
  - W_real = round(256·cos(2πk/N)).
  - W_imag = −round(256·sin(2πk/N)).
  - For N=4: k0 = (256, 0), k1 = (0, −256).
- No `adv` in a cycle: `out_valid`=0 and `out_first`=0 next cycle. Data and twiddle outputs hold their last values.

## Timing
- Latency: one cycle. All outputs are registered and update on the edge after the accepting `adv` edge.
- A sum for pair (x[n], x[n+N/2]) is valid one cycle after x[n+N/2] is accepted.
- The difference for pair n is valid one cycle after the n-th sample of the next frame (or flush) is accepted.
- Twiddle and data are always presented in the same cycle. The multiplier consumes them together.
- Reset values: `cnt`=0, `pending`=0, `out_valid`=0, `out_first`=0. `out_r`, `out_i`, `W_real`, `W_imag` are all 0.
- Delay-line contents are not reset; `pending`=0 masks them.
- Reset mid-frame discards the partial frame and any pending differences. The first `adv` after reset is sample 0 of a new frame.
- Gaps in `in_valid` are allowed anywhere. Frame alignment is kept because state only moves on `adv`.
- Back-to-back frames give one valid output per `adv` after the first N/2 cycles.

## Test plan
- Reset, N=4, then stream real frame (100, 200, 300, 400), imag 0. The outputs after x[2] and x[3] must be (200, 0) and (300, 0), each with W=(256, 0). `out_first`=1 on the first of the two.
- Follow the first frame with 2 flush cycles. The outputs must be (−100, 0) with W=(256, 0), then (−100, 0) with W=(0, −256). `pending`=0 afterwards.
- Send two back-to-back frames (100, 200, 300, 400) and (1, 2, 3, 4). `out_valid` must be continuous from cycle 3. The first frame's differences must interleave in the order: sums of frame 1 → diffs of frame 1 → sums of frame 2.
- Insert random `in_valid` gaps into the frame above. The output sequence must be identical to the gapless run.
- Feed a frame of all −32768, then flush. The sum must be −32768, the diff 0, with no overflow. A pair (−1, 0) must give sum −1 (floor).
- Assert `reset` after x[1] of a frame, then send a fresh frame. No stale output may appear. The first valid outputs must be the sums of the fresh frame.
